// File: rtl/varredura_display.sv
// Four-digit 7-segment scan driver: write-addressed pattern bank, prescaled digit rotation,
// active-low one-hot enables. Optional anti-ghosting dead time under VARREDURA_BLANK_EN.
module varredura_display #(
  parameter int unsigned DIVISOR      = 50000,
  parameter int unsigned LARGURA_CONT = 20,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Habilita,
  input  logic       Escrita,
  input  logic [1:0] Endereco,
  input  logic [6:0] Dado,
  output logic [6:0] Segmentos,
  output logic [3:0] Digito,
  output logic [1:0] Selecao,
  output logic       Fim_Varredura
);

  localparam logic [LARGURA_CONT-1:0] ULTIMO = LARGURA_CONT'(DIVISOR - 1);

  // Elaboration-time parameter sanity checks; nothing is synthesized here.
  if ((DIVISOR < 1) || (DIVISOR > (1 << LARGURA_CONT))) begin : g_bad_divisor
    $error("varredura_display: DIVISOR out of range for LARGURA_CONT");
  end
  if (BLANK_CYCLES >= DIVISOR) begin : g_bad_blank
    $error("varredura_display: BLANK_CYCLES must be less than DIVISOR");
  end

  logic [LARGURA_CONT-1:0] presc_r;
  logic [LARGURA_CONT-1:0] presc_next_s;
  logic [1:0]              sel_next_s;
  logic                    fim_next_s;
  logic                    lit_s;
  logic [6:0]              bank_r      [4];
  logic [6:0]              bank_next_s [4];
  logic [6:0]              seg_next_s;
  logic [3:0]              dig_next_s;

  // Prescaler and digit index advance; the wrap pulse marks 3 -> 0.
  always_comb begin
    presc_next_s = presc_r;
    sel_next_s   = Selecao;
    fim_next_s   = 1'b0;
    if (Habilita) begin
      if (presc_r == ULTIMO) begin
        presc_next_s = '0;
        sel_next_s   = Selecao + 2'd1;
        fim_next_s   = (Selecao == 2'd3);
      end else begin
        presc_next_s = presc_r + LARGURA_CONT'(1);
      end
    end else begin
      presc_next_s = presc_r;
      sel_next_s   = Selecao;
    end
  end

  // Write port merged ahead of the output mux so a write to the lit digit shows at once.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (Escrita && (Endereco == 2'(i))) begin
        bank_next_s[i] = Dado;
      end else begin
        bank_next_s[i] = bank_r[i];
      end
    end
  end

  // Display is dark while frozen, and during the dead time when that feature is built in.
  always_comb begin
`ifdef VARREDURA_BLANK_EN
    lit_s = Habilita && (presc_next_s >= LARGURA_CONT'(BLANK_CYCLES));
`else
    lit_s = Habilita;
`endif
    seg_next_s = 7'd0;
    dig_next_s = 4'b1111;
    if (lit_s) begin
      seg_next_s = bank_next_s[sel_next_s];
      case (sel_next_s)
        2'd0:    dig_next_s = 4'b1110;
        2'd1:    dig_next_s = 4'b1101;
        2'd2:    dig_next_s = 4'b1011;
        2'd3:    dig_next_s = 4'b0111;
        default: dig_next_s = 4'b1111;
      endcase
    end else begin
      seg_next_s = 7'd0;
      dig_next_s = 4'b1111;
    end
  end

  // State and registered outputs; reset discards any write in the same cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      presc_r       <= '0;
      Selecao       <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        bank_r[i] <= 7'd0;
      end
      Segmentos     <= 7'd0;
      Digito        <= 4'b1111;
      Fim_Varredura <= 1'b0;
    end else begin
      presc_r       <= presc_next_s;
      Selecao       <= sel_next_s;
      for (int i = 0; i < 4; i++) begin
        bank_r[i] <= bank_next_s[i];
      end
      Segmentos     <= seg_next_s;
      Digito        <= dig_next_s;
      Fim_Varredura <= fim_next_s;
    end
  end

endmodule
